// File: rtl/offset_strip_pipe.sv
// offset_strip_pipe
//   Decoder for per-channel constant-offset encoding: data = code - off(ch)
//   mod 2^W. Two registered stages with valid/ready flow control, full
//   throughput under backpressure, a borrow flag (code < offset), an error
//   flag for the illegal channel 3 and a wrapping completed-item counter.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data [W-1:0]     offset-encoded code
//   in_ch   [1:0]       channel (3 = illegal, passed through with err)
//   out_valid/out_ready output handshake
//   out_data [W-1:0]    decoded value
//   out_ch  [1:0]       channel passed through
//   out_borrow          subtraction wrapped
//   out_err             beat carried channel 3
//   item_cnt [CNT_W-1:0] completed output handshakes, wraps
module offset_strip_pipe #(
  parameter int W       = 8,
  parameter int P       = 23,
  parameter int P_A     = 42,
  parameter int P_B_ADD = 42,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_ch,
  output logic             out_borrow,
  output logic             out_err,
  output logic [CNT_W-1:0] item_cnt
);

  localparam int STAGES = 2;

  // Offsets are folded to W bits at elaboration; ch1 sum wraps like the encoder.
  localparam logic [W-1:0] OFF0 = W'(P_A);
  localparam logic [W-1:0] OFF1 = W'(P + P_B_ADD);
  localparam logic [W-1:0] OFF2 = W'(P);

  typedef struct packed {
    logic [W-1:0] code;
    logic [1:0]   ch;
    logic [W-1:0] off;
    logic         err;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1;
  logic [W-1:0]    off_sel;
  logic            err_sel;
  logic [W:0]      diff;
  logic            s1_load, s2_load, done;

  // S2 frees up when empty or draining this cycle; S1 follows S2.
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign s1_load   = !vld_pipe[1] || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = vld_pipe[2];
  assign done      = vld_pipe[2] && out_ready;

  always_comb begin
    off_sel = '0;
    err_sel = 1'b0;
    case (in_ch)
      2'd0:    off_sel = OFF0;
      2'd1:    off_sel = OFF1;
      2'd2:    off_sel = OFF2;
      default: err_sel = 1'b1;  // zero offset: code passes through untouched
    endcase
  end

  // Extra MSB captures the borrow out of the W-bit subtraction.
  assign diff = {1'b0, s1.code} - {1'b0, s1.off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1         <= '0;
      out_data   <= '0;
      out_ch     <= '0;
      out_borrow <= 1'b0;
      out_err    <= 1'b0;
      item_cnt   <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1 <= '{code: in_data, ch: in_ch, off: off_sel, err: err_sel};
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data   <= diff[W-1:0];
          out_borrow <= diff[W];
          out_err    <= s1.err;
          out_ch     <= s1.ch;
        end
      end
      if (done) item_cnt <= item_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_offset_strip_pipe.sv
// Directed bench for offset_strip_pipe: single-beat decode per channel,
// illegal channel, backpressure hold/drain, full round trip with random
// out_ready, counter wrap on a CNT_W=4 instance, and async reset mid-stream.
module tb_offset_strip_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_borrow, out_err;
  logic [7:0] in_data, out_data;
  logic [1:0] in_ch, out_ch;
  logic [15:0] item_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_borrow, b_out_err;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_in_ch, b_out_ch;
  logic [3:0] b_item_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int idx, oidx, cyc;
  bit acc, seen;

  logic [7:0] q_data[$];
  logic [1:0] q_ch[$];
  logic [9:0] q_exp[$];

  always #5 clk = ~clk;

  offset_strip_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_borrow(out_borrow), .out_err(out_err),
    .item_cnt(item_cnt)
  );

  offset_strip_pipe #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ch(b_in_ch), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_borrow(b_out_borrow), .out_err(b_out_err),
    .item_cnt(b_item_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge with an empty pipe and out_ready = 1.
  task automatic send_one(input string tag, input logic [1:0] ch, input logic [7:0] code,
                          input logic [7:0] exp_d, input logic exp_b, input logic exp_e);
    in_valid = 1'b1; in_ch = ch; in_data = code; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_early"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_out"}, {out_valid, out_err, out_borrow, out_ch, out_data},
        {1'b1, exp_e, exp_b, ch, exp_d});
    @(posedge clk); #1;
    exp_cnt++;
    chk({tag, "_cnt"}, 32'(item_cnt), exp_cnt & 32'hFFFF);
    chk({tag, "_drained"}, 32'(out_valid), 0);
  endtask

  // Streams q_data/q_ch from idx, compares outputs against q_exp from oidx.
  task automatic run_stream(input bit rnd, input int budget, output int ncyc);
    ncyc = 0;
    while (oidx < q_exp.size() && ncyc < budget) begin
      in_valid = (idx < q_data.size());
      if (in_valid) begin in_data = q_data[idx]; in_ch = q_ch[idx]; end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("stream_beat", {out_ch, out_data}, q_exp[oidx]);
        oidx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      ncyc++;
    end
    in_valid = 1'b0;
    chk("stream_done", oidx, q_exp.size());
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h33; b_in_ch = 2'd2; b_out_ready = 1'b1;
    #12;
    chk("rst_state", {out_valid, out_err, out_borrow, out_ch, out_data}, 0);
    chk("rst_cnt", 32'(item_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter wrap on the 4-bit instance: 17 handshakes -> 1.
    b_in_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cnt_wrap", 32'(b_item_cnt), 1);

    // Single decodes.
    send_one("ch0", 2'd0, 8'h50, 8'h26, 1'b0, 1'b0);
    send_one("ch2", 2'd2, 8'd100, 8'd77, 1'b0, 1'b0);
    send_one("ch1", 2'd1, 8'h10, 8'hCF, 1'b1, 1'b0);
    send_one("ch3", 2'd3, 8'h07, 8'h07, 1'b0, 1'b1);

    // Backpressure: 4 ch0 beats against a stalled sink.
    q_data.delete(); q_ch.delete(); q_exp.delete();
    for (int k = 0; k < 4; k++) begin
      q_data.push_back(8'(42 + k)); q_ch.push_back(2'd0); q_exp.push_back(10'(k));
    end
    idx = 0; oidx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (in_valid) begin in_data = q_data[idx]; in_ch = q_ch[idx]; end
      out_ready = 1'b0;
      @(negedge clk);
      if (out_valid) chk("stall_hold", 32'(out_data), 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    @(negedge clk);
    chk("stall_accepts", idx, 2);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_valid", {out_valid, out_data}, {1'b1, 8'h00});
    @(posedge clk); #1;
    run_stream(1'b0, 20, cyc);
    chk("drain_no_gap", cyc, 4);
    exp_cnt += 4;
    chk("drain_cnt", 32'(item_cnt), exp_cnt & 32'hFFFF);

    // Round trip: every x on every legal channel, random sink readiness.
    q_data.delete(); q_ch.delete(); q_exp.delete();
    for (int ch = 0; ch < 3; ch++) begin
      for (int x = 0; x < 256; x++) begin
        q_data.push_back(8'(x + (ch == 0 ? 42 : ch == 1 ? 65 : 23)));
        q_ch.push_back(2'(ch));
        q_exp.push_back({2'(ch), 8'(x)});
      end
    end
    idx = 0; oidx = 0;
    run_stream(1'b1, 6000, cyc);
    exp_cnt += 768;
    chk("rt_cnt", 32'(item_cnt), exp_cnt & 32'hFFFF);

    // Reset with both stages full.
    in_valid = 1'b1; in_ch = 2'd1; in_data = 8'h10; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("full_out", {out_valid, out_borrow, out_ch, out_data}, {1'b1, 1'b1, 2'd1, 8'hCF});
    chk("full_in_ready", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {out_valid, out_err, out_borrow, out_ch, out_data}, 0);
    chk("async_rst_cnt", 32'(item_cnt), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_idle", 32'(seen), 0);
    chk("post_rst_cnt", 32'(item_cnt), 0);
    @(posedge clk); #1;
    exp_cnt = 0;
    send_one("post_rst", 2'd2, 8'd100, 8'd77, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/offset_strip_pipe.md
Name: offset_strip_pipe

Overview:
- Decoder side of the per-channel constant-offset encoding. The encoder computes code = data + offset mod 2^W; this block recovers data = code - offset mod 2^W.
- Channel offsets: ch0 = P_A, ch1 = P + P_B_ADD, ch2 = P.
- Two-stage valid/ready pipeline with full throughput under backpressure, borrow/error flags and a processed-item counter.
- Sits between the offset-encoded stream source and downstream consumers.

Parameters:
- W, 8, data width.
- P, 23, base offset; ch2 offset.
- P_A, 42, ch0 offset.
- P_B_ADD, 42, ch1 offset is P+P_B_ADD (default 65); the sum is computed at elaboration and truncated to W bits.
- CNT_W, 16, width of item counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  W  offset-encoded code
- in_ch  input  2  channel select (0..2 valid, 3 illegal)
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_data  output  W  decoded value
- out_ch  output  2  channel passed through
- out_borrow  output  1  code < offset, i.e. subtraction wrapped
- out_err  output  1  beat had in_ch==3
- item_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset (async assert, sync-safe deassert edge): both stage valids = 0, out_valid = 0, out_data = 0, out_ch = 0, out_borrow = 0, out_err = 0, item_cnt = 0. Assertion mid-transfer drops all in-flight beats; nothing is emitted after release.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat completes when out_valid && out_ready.
- Stage S1 register on accept: code, ch, offset, where offset = P_A for ch0, P+P_B_ADD for ch1, P for ch2, and 0 for ch3 with err = 1.
- Stage S2 register on S1 advance:
  - Compute diff = {1'b0,code} - {1'b0,offset} in W+1 bits.
  - out_data = diff[W-1:0]; out_borrow = diff[W]; out_err = S1 err; out_ch = S1 ch.
  - out_valid = S2 valid.
- Latency: an accepted beat is visible on out_* 2 cycles later when there is no stall.
- Advance rules:
  - S2 loads when S2 is empty or completing this cycle.
  - S1 loads when S1 is empty or S1 advances into S2 this cycle.
  - in_ready = !S1valid || S1 advancing. in_ready is combinational from out_ready; no skid buffer is needed.
  - Throughput: 1 beat/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, out_data, out_ch, out_borrow, out_err and out_valid hold stable. At most 2 beats are held; with both stages full, in_ready = 0.
- Simultaneous accept and complete on a full pipe: both stages shift in the same cycle; no beat is lost or duplicated.
- Ordering: strict FIFO order; no reordering by channel.
- item_cnt: +1 per completed output handshake, including err beats; wraps from 2^CNT_W-1 to 0; no saturation.
- ch3 beats are passed through, never dropped: data unchanged, borrow = 0, err = 1.
- Round-trip property: for any x and ch in 0..2, input (x + off(ch)) mod 2^W produces out_data == x.

Test Plan:
- Decode, no stall (out_ready = 1):
  - ch0 in 0x50 -> out 0x26, borrow 0, out_valid 2 cycles after accept.
  - ch2 in 100 -> out 77.
  - ch1 in 0x10 -> out 0xCF, borrow 1.
- Illegal channel: ch3 in 0x07 -> out 0x07, err 1, borrow 0; item_cnt increments by 1.
- Backpressure:
  - Hold out_ready = 0 while streaming 4 beats (ch0 codes 42, 43, 44, 45). in_ready must drop after 2 accepts, and out_data must hold 0 stable.
  - Release out_ready -> outputs 0, 1, 2, 3 in order with no gap or duplicate; item_cnt = 4.
- Round trip: all 256 x × ch0..2 with encoded input (x + off) & 0xFF, random out_ready -> every out_data == x, in order.
- Counter wrap: CNT_W = 4, 17 completed beats -> item_cnt = 1.
- Reset mid-stream:
  - Assert rst_n = 0 with both stages full -> all outputs are 0 immediately (async).
  - After release, out_valid stays 0 until a new beat is accepted; item_cnt = 0.
